// File: rtl/alu_host_cmd_if.sv
// Host-side command/byte-stream/response bundle for alu_host_cmd.
// The slave modport is the alu_host_cmd side; master is whoever drives commands
// and emulates the UART byte streams.
interface alu_host_cmd_if;
    logic [7:0]  cmd_opcode_i;
    logic [31:0] cmd_operand_a_i;
    logic [31:0] cmd_operand_b_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  tx_tdata_o;
    logic        tx_tvalid_o;
    logic        tx_tready_i;
    logic [7:0]  rx_tdata_i;
    logic        rx_tvalid_i;
    logic        rx_tready_o;
    logic [31:0] rsp_data_o;
    logic        rsp_error_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;

    modport slave (
        input  cmd_opcode_i, cmd_operand_a_i, cmd_operand_b_i, cmd_valid_i,
        output cmd_ready_o,
        output tx_tdata_o, tx_tvalid_o,
        input  tx_tready_i,
        input  rx_tdata_i, rx_tvalid_i,
        output rx_tready_o,
        output rsp_data_o, rsp_error_o, rsp_valid_o,
        input  rsp_ready_i
    );

    modport master (
        output cmd_opcode_i, cmd_operand_a_i, cmd_operand_b_i, cmd_valid_i,
        input  cmd_ready_o,
        input  tx_tdata_o, tx_tvalid_o,
        output tx_tready_i,
        output rx_tdata_i, rx_tvalid_i,
        input  rx_tready_o,
        input  rsp_data_o, rsp_error_o, rsp_valid_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/alu_host_cmd.sv
// alu_host_cmd: host-side initiator for the UART ALU packet protocol.
// Serialises one command into a 12-byte packet, then gathers a 4-byte
// little-endian result (or aborts on a response timeout). All outputs are
// registered; the FSM computes every next-state value in one comb process.
module alu_host_cmd #(
    parameter int unsigned TimeoutCycles = 1000000
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    alu_host_cmd_if.slave bus
);

    localparam int unsigned TimerW = $clog2(TimeoutCycles);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 32'd1);
    localparam logic [TimerW-1:0] TimerOne  = TimerW'(32'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Packet byte at a given index: opcode, 16-bit LE length (12), A LE, B LE.
    function automatic logic [7:0] pkt_byte(
        input logic [3:0]  idx,
        input logic [7:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [7:0] r;
        case (idx)
            4'd0:    r = op;
            4'd1:    r = 8'h00;
            4'd2:    r = 8'h0C;
            4'd3:    r = 8'h00;
            4'd4:    r = a[7:0];
            4'd5:    r = a[15:8];
            4'd6:    r = a[23:16];
            4'd7:    r = a[31:24];
            4'd8:    r = b[7:0];
            4'd9:    r = b[15:8];
            4'd10:   r = b[23:16];
            4'd11:   r = b[31:24];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [7:0]        opcode_r, opcode_s;
    logic [31:0]       operand_a_r, operand_a_s;
    logic [31:0]       operand_b_r, operand_b_s;
    logic [3:0]        tx_idx_r, tx_idx_s;
    logic [1:0]        rx_idx_r, rx_idx_s;
    logic [TimerW-1:0] timer_r, timer_s;
    logic              cmd_ready_r, cmd_ready_s;
    logic [7:0]        tx_tdata_r, tx_tdata_s;
    logic              tx_tvalid_r, tx_tvalid_s;
    logic              rx_tready_r, rx_tready_s;
    logic [31:0]       rsp_data_r, rsp_data_s;
    logic              rsp_error_r, rsp_error_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              rx_beat_s;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        opcode_s    = opcode_r;
        operand_a_s = operand_a_r;
        operand_b_s = operand_b_r;
        tx_idx_s    = tx_idx_r;
        rx_idx_s    = rx_idx_r;
        timer_s     = timer_r;
        tx_tdata_s  = tx_tdata_r;
        tx_tvalid_s = tx_tvalid_r;
        rsp_data_s  = rsp_data_r;
        rsp_error_s = rsp_error_r;
        rsp_valid_s = rsp_valid_r;
        rx_tready_s = 1'b1;
        rx_beat_s   = bus.rx_tvalid_i & rx_tready_r;

        case (state_r)
            IDLE: begin
                if (bus.cmd_valid_i && cmd_ready_r) begin
                    opcode_s    = bus.cmd_opcode_i;
                    operand_a_s = bus.cmd_operand_a_i;
                    operand_b_s = bus.cmd_operand_b_i;
                    tx_idx_s    = 4'd0;
                    rsp_data_s  = 32'h0000_0000;
                    rsp_error_s = 1'b0;
                    tx_tvalid_s = 1'b1;
                    tx_tdata_s  = bus.cmd_opcode_i;
                    state_s     = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (tx_tvalid_r && bus.tx_tready_i) begin
                    if (tx_idx_r == 4'd11) begin
                        tx_tvalid_s = 1'b0;
                        tx_tdata_s  = 8'h00;
                        rx_idx_s    = 2'd0;
                        timer_s     = '0;
                        state_s     = WAIT_RSP;
                    end else begin
                        tx_idx_s   = tx_idx_r + 4'd1;
                        tx_tdata_s = pkt_byte(tx_idx_r + 4'd1, opcode_r, operand_a_r, operand_b_r);
                    end
                end else begin
                    state_s = SEND;
                end
            end
            WAIT_RSP: begin
                // A beat always wins over an expiring timer.
                if (rx_beat_s) begin
                    rsp_data_s[{rx_idx_r, 3'b000} +: 8] = bus.rx_tdata_i;
                    rx_idx_s = rx_idx_r + 2'd1;
                    timer_s  = '0;
                    if (rx_idx_r == 2'd3) begin
                        rsp_error_s = 1'b0;
                        rsp_valid_s = 1'b1;
                        state_s     = DONE;
                    end else begin
                        state_s = WAIT_RSP;
                    end
                end else if (timer_r == TimerLast) begin
                    rsp_error_s = 1'b1;
                    rsp_valid_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    timer_s = timer_r + TimerOne;
                end
            end
            DONE: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                tx_tvalid_s = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase

        cmd_ready_s = (state_s == IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r     <= IDLE;
            opcode_r    <= 8'h00;
            operand_a_r <= 32'h0000_0000;
            operand_b_r <= 32'h0000_0000;
            tx_idx_r    <= 4'd0;
            rx_idx_r    <= 2'd0;
            timer_r     <= '0;
            cmd_ready_r <= 1'b0;
            tx_tdata_r  <= 8'h00;
            tx_tvalid_r <= 1'b0;
            rx_tready_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            opcode_r    <= opcode_s;
            operand_a_r <= operand_a_s;
            operand_b_r <= operand_b_s;
            tx_idx_r    <= tx_idx_s;
            rx_idx_r    <= rx_idx_s;
            timer_r     <= timer_s;
            cmd_ready_r <= cmd_ready_s;
            tx_tdata_r  <= tx_tdata_s;
            tx_tvalid_r <= tx_tvalid_s;
            rx_tready_r <= rx_tready_s;
            rsp_data_r  <= rsp_data_s;
            rsp_error_r <= rsp_error_s;
            rsp_valid_r <= rsp_valid_s;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_r;
    assign bus.tx_tdata_o  = tx_tdata_r;
    assign bus.tx_tvalid_o = tx_tvalid_r;
    assign bus.rx_tready_o = rx_tready_r;
    assign bus.rsp_data_o  = rsp_data_r;
    assign bus.rsp_error_o = rsp_error_r;
    assign bus.rsp_valid_o = rsp_valid_r;

endmodule

// File: tb/tb_alu_host_cmd.sv
// Testbench for alu_host_cmd: table of commands with hand-computed packets and
// responses, plus hand-written hold/back-to-back and mid-packet reset sequences.
module tb_alu_host_cmd;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_host_cmd_if bus ();

    alu_host_cmd #(.TimeoutCycles(50)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [95:0] tx_exp;    // byte 0 in bits [95:88]
        logic [31:0] rx_bytes;  // byte 0 in bits [7:0]
        int          rx_cnt;
        logic [31:0] rsp_exp;
        logic        err_exp;
        int          lat_exp;   // clock edges after the last rx beat edge
        bit          rand_ready;
        bit          stray;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold);
        int          idx;
        int          guard;
        int          cnt;
        bit          stable_ok;
        bit          prev_stall;
        bit          hold_ok;
        logic [7:0]  prev_d;
        logic [95:0] txe;
        logic [31:0] held;
        txe = v.tx_exp;

        guard = 0;
        while (!bus.cmd_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);

        if (v.stray) begin
            bus.rx_tvalid_i = 1'b1;
            bus.rx_tdata_i  = 8'h55;
            @(negedge clk);
            bus.rx_tvalid_i = 1'b0;
        end

        bus.cmd_opcode_i    = v.op;
        bus.cmd_operand_a_i = v.a;
        bus.cmd_operand_b_i = v.b;
        bus.cmd_valid_i     = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        check("first_tvalid", 32'(bus.tx_tvalid_o), 32'd1);
        check("first_tdata", 32'(bus.tx_tdata_o), 32'(txe[95:88]));
        check("cmd_ready_busy", 32'(bus.cmd_ready_o), 32'd0);

        idx = 0;
        guard = 0;
        stable_ok = 1'b1;
        prev_stall = 1'b0;
        prev_d = 8'h00;
        while (idx < 12 && guard < 400) begin
            bus.tx_tready_i = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.stray && idx == 3) begin
                bus.rx_tvalid_i = 1'b1;
                bus.rx_tdata_i  = 8'h66;
            end else begin
                bus.rx_tvalid_i = 1'b0;
            end
            if (prev_stall && (bus.tx_tdata_o !== prev_d || bus.tx_tvalid_o !== 1'b1))
                stable_ok = 1'b0;
            if (bus.tx_tvalid_o && bus.tx_tready_i) begin
                check($sformatf("tx_byte%0d", idx), 32'(bus.tx_tdata_o), 32'(txe[95-8*idx -: 8]));
                idx++;
            end
            prev_stall = bus.tx_tvalid_o && !bus.tx_tready_i;
            prev_d = bus.tx_tdata_o;
            @(negedge clk);
            guard++;
        end
        bus.tx_tready_i = 1'b0;
        bus.rx_tvalid_i = 1'b0;
        check("tx_byte_count", 32'(idx), 32'd12);
        check("tx_drop", 32'(bus.tx_tvalid_o), 32'd0);
        check("tx_stable", 32'(stable_ok), 32'd1);

        for (int i = 0; i < v.rx_cnt; i++) begin
            bus.rx_tvalid_i = 1'b1;
            bus.rx_tdata_i  = v.rx_bytes[8*i +: 8];
            if (i < v.rx_cnt - 1) @(negedge clk);
        end
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            bus.rx_tvalid_i = 1'b0;
        end while (!bus.rsp_valid_o && cnt < 200);
        check("rsp_latency", 32'(cnt - 1), 32'(v.lat_exp));
        check("rsp_data", bus.rsp_data_o, v.rsp_exp);
        check("rsp_error", 32'(bus.rsp_error_o), 32'(v.err_exp));

        if (hold) begin
            bus.cmd_opcode_i    = 8'h3C;
            bus.cmd_operand_a_i = 32'h4433_2211;
            bus.cmd_operand_b_i = 32'hA5A5_A5A5;
            bus.cmd_valid_i     = 1'b1;
            held = bus.rsp_data_o;
            hold_ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== held ||
                    bus.rsp_error_o !== v.err_exp || bus.cmd_ready_o !== 1'b0)
                    hold_ok = 1'b0;
            end
            check("done_hold", 32'(hold_ok), 32'd1);
        end

        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("rsp_valid_drop", 32'(bus.rsp_valid_o), 32'd0);
        check("cmd_ready_back", 32'(bus.cmd_ready_o), 32'd1);

        if (hold) begin
            @(negedge clk);
            bus.cmd_valid_i = 1'b0;
            check("b2b_tvalid", 32'(bus.tx_tvalid_o), 32'd1);
            check("b2b_tdata", 32'(bus.tx_tdata_o), 32'h3C);
        end
    endtask

    // Main stimulus.
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.cmd_opcode_i    = 8'h00;
        bus.cmd_operand_a_i = 32'h0;
        bus.cmd_operand_b_i = 32'h0;
        bus.cmd_valid_i     = 1'b0;
        bus.tx_tready_i     = 1'b0;
        bus.rx_tdata_i      = 8'h00;
        bus.rx_tvalid_i     = 1'b0;
        bus.rsp_ready_i     = 1'b0;

        vecs[0] = '{8'hAD, 32'h0D4B_02FF, 32'h8765_4321, 96'hAD_00_0C_00_FF_02_4B_0D_21_43_65_87,
                    32'h94B0_4620, 4, 32'h94B0_4620, 1'b0, 0, 1'b0, 1'b0};
        vecs[1] = '{8'hAD, 32'h0D4B_02FF, 32'h8765_4321, 96'hAD_00_0C_00_FF_02_4B_0D_21_43_65_87,
                    32'h94B0_4620, 4, 32'h94B0_4620, 1'b0, 0, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 32'h0123_4567, 32'h89AB_CDEF, 96'h5A_00_0C_00_67_45_23_01_EF_CD_AB_89,
                    32'h0000_0001, 4, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b1};
        vecs[3] = '{8'hAD, 32'h0000_0000, 32'hFFFF_FFFF, 96'hAD_00_0C_00_00_00_00_00_FF_FF_FF_FF,
                    32'h0000_2211, 2, 32'h0000_2211, 1'b1, 50, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        check("rst_tx_tvalid", 32'(bus.tx_tvalid_o), 32'd0);
        check("rst_tx_tdata", 32'(bus.tx_tdata_o), 32'd0);
        check("rst_rx_tready", 32'(bus.rx_tready_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_error", 32'(bus.rsp_error_o), 32'd0);
        check("rst_rsp_data", bus.rsp_data_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_rx_tready", 32'(bus.rx_tready_o), 32'd1);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

        for (int k = 0; k < 4; k++) run_vec(vecs[k], 1'b0);

        // Hold response with a command pending, then back-to-back acceptance.
        run_vec(vecs[0], 1'b1);

        // Back-to-back command 0x3C is now on byte 0; send five bytes then reset.
        bus.tx_tready_i = 1'b1;
        repeat (5) @(negedge clk);
        bus.tx_tready_i = 1'b0;
        check("pre_rst_byte5", 32'(bus.tx_tdata_o), 32'h22);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(bus.tx_tvalid_o), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        check("mid_rst_tdata", 32'(bus.tx_tdata_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("rel_tvalid", 32'(bus.tx_tvalid_o), 32'd0);
        run_vec(vecs[2], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/alu_host_cmd.md
Name: alu_host_cmd

Overview:
- Host-side initiator for the UART ALU packet protocol; it is the other end from alu_wrap.
- Accepts one ADD-style command (opcode plus two 32-bit operands) and serialises it into a 12-byte packet on a byte AXI-stream feeding uart_tx.
- Collects the 4-byte little-endian result from a uart_rx byte stream and presents it as one 32-bit response with an error flag.
- Used in on-chip self-test and as a bench-side driver.

Parameters:
TimeoutCycles, 1000000, max cycles allowed in WAIT_RSP with no response byte before the transaction is aborted; legal range 2..2^24.

Ports:
clk_i  input  1  sole clock
reset_ni  input  1  asynchronous active-low reset
cmd_opcode_i  input  8  packet opcode byte, e.g. 0xAD = add
cmd_operand_a_i  input  32  operand A
cmd_operand_b_i  input  32  operand B
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
tx_tdata_o  output  8  byte to uart_tx
tx_tvalid_o  output  1  byte valid
tx_tready_i  input  1  uart_tx ready
rx_tdata_i  input  8  byte from uart_rx
rx_tvalid_i  input  1  rx byte valid
rx_tready_o  output  1  always 1 out of reset
rsp_data_o  output  32  assembled result
rsp_error_o  output  1  1 = timeout abort; valid with rsp_valid_o
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumer ready

Behaviour:
- Reset is asynchronous assert, synchronous deassert handled upstream. While reset is low: state=IDLE, all counters 0, cmd_ready_o=0, tx_tvalid_o=0, tx_tdata_o=0, rsp_valid_o=0, rsp_error_o=0, rsp_data_o=0, rx_tready_o=0.
- After reset: rx_tready_o=1 in every state; the block never back-pressures uart_rx.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o, register opcode, A and B.
  - Clear byte index tx_idx=0 and rsp_data_o=0.
  - Go to SEND; cmd_ready_o is 0 from the next cycle.
- SEND:
  - tx_tvalid_o=1, tx_tdata_o = byte[tx_idx] of the packet.
  - Packet byte order: opcode, 0x00, 0x0C, 0x00, A[7:0], A[15:8], A[23:16], A[31:24], B[7:0], B[15:8], B[23:16], B[31:24].
  - Length field is the total packet length, 16-bit little-endian.
  - tx_idx advances only on tx_tvalid_o&tx_tready_i.
  - tx_tdata_o is stable while valid and not ready.
  - The first byte is presented the cycle after command acceptance.
  - On the handshake of byte 11, drop tx_tvalid_o the next cycle and go to WAIT_RSP with rx_idx=0 and timer=0.
- WAIT_RSP:
  - Each rx_tvalid_i beat writes rx_tdata_i into rsp_data_o[8*rx_idx +: 8], increments rx_idx and clears the timer.
  - A beat with rx_idx==3 goes to DONE with rsp_error_o=0.
  - With no beat in a cycle, the timer increments.
  - When the timer reaches TimeoutCycles-1 with no beat that cycle, go to DONE with rsp_error_o=1. Bytes not received remain 0.
  - A beat on the same cycle the timer would expire wins: the byte is taken and the timer is cleared.
  - The timer width is $clog2(TimeoutCycles).
- DONE:
  - rsp_valid_o=1; rsp_data_o and rsp_error_o are held stable.
  - On rsp_valid_o&rsp_ready_i, go to IDLE the next cycle with rsp_valid_o=0. cmd_ready_o returns to 1 that same cycle.
  - Back-to-back command acceptance is therefore possible one cycle after the response handshake.
- Stray rx beats in IDLE, SEND or DONE are consumed and discarded; they never alter rsp_data_o.
- Reset asserted mid-SEND or mid-WAIT_RSP aborts immediately to the reset values. No partial byte is re-sent after reset.
- Latency: command accept to first tx byte is 1 cycle; last rx byte to rsp_valid_o is 1 cycle.

Test Plan:
- Command opcode=0xAD, A=0x0D4B02FF, B=0x87654321 with tx_tready_i=1, then rx bytes 20 46 B0 94 -> tx sequence AD 00 0C 00 FF 02 4B 0D 21 43 65 87; rsp_data_o=0x94B04620, rsp_error_o=0, rsp_valid_o one cycle after last rx byte.
- Same command with tx_tready_i toggling with a random 50% duty -> identical 12-byte sequence; tx_tdata_o never changes while tx_tvalid_o=1 and tx_tready_i=0.
- TimeoutCycles=50, deliver rx bytes 0x11 then 0x22, then nothing -> rsp_valid_o with rsp_error_o=1 and rsp_data_o=0x00002211, exactly 50 cycles after the 0x22 beat.
- Rx bytes 0x55 0x66 injected in IDLE and during SEND, then a normal response 01 00 00 00 -> rsp_data_o=0x00000001; stray bytes ignored.
- Hold rsp_ready_i=0 for 20 cycles in DONE, with cmd_valid_i asserted throughout -> rsp_valid_o and data stay stable and cmd_ready_o=0; release, then the next command is accepted the cycle after the response handshake.
- Pull reset_ni low after 5 tx bytes -> tx_tvalid_o=0 and cmd_ready_o=0 immediately; after release cmd_ready_o=1, and a new command starts again at byte 0 (opcode).
